// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the CPU data-memory request/ready handshake, backed by a
// single-port word RAM that completes each access LATENCY cycles after it is sampled.
// Build option: define DMEM_ERR_EN to flag misaligned or out-of-range addresses on dmem_error.
module dmem_responder #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_write_data,
    input  logic                  dmem_read,
    input  logic                  dmem_write,
    output logic [DATA_WIDTH-1:0] dmem_read_data,
    output logic                  dmem_ready,
    output logic                  dmem_busy,
    output logic                  dmem_error
);

    localparam int         IDX_W  = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  op_wr_q, op_wr_d;
    logic                  op_rd_q, op_rd_d;
    logic                  err_q, err_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  req_start;
    logic [IDX_W-1:0]      req_idx;
    logic                  req_err;

    logic                  complete;
    logic [IDX_W-1:0]      acc_idx;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  acc_wr;
    logic                  acc_rd;
    logic                  acc_err;
    logic                  mem_we;
    logic                  mem_re;

    // The ready cycle is IDLE but must not re-sample the request still being held.
    assign req_start = (state_q == S_IDLE) && !ready_q && (dmem_read || dmem_write);
    assign req_idx   = dmem_addr[IDX_W+2:3];

`ifdef DMEM_ERR_EN
    assign req_err = (dmem_addr[2:0] != 3'b000) ||
                     (dmem_addr[ADDR_WIDTH-1:IDX_W+3] != '0);
`else
    logic addr_unused;
    assign addr_unused = ^{dmem_addr[2:0], dmem_addr[ADDR_WIDTH-1:IDX_W+3]};
    assign req_err     = 1'b0;
`endif

    // With LATENCY=1 the access completes at the sampling edge, straight from the live bus.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_idx   = req_idx;
            acc_wdata = dmem_write_data;
            acc_wr    = dmem_write;
            acc_rd    = dmem_read;
            acc_err   = req_err;
        end else begin
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
            acc_wr    = op_wr_q;
            acc_rd    = op_rd_q;
            acc_err   = err_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        op_wr_d  = op_wr_q;
        op_rd_d  = op_rd_q;
        err_d    = err_q;
        complete = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_start) begin
                    idx_d   = req_idx;
                    wdata_d = dmem_write_data;
                    op_wr_d = dmem_write;
                    op_rd_d = dmem_read;
                    err_d   = req_err;
                    cnt_d   = LAT_M1;
                    if (LAT_M1 == 4'd0) begin
                        complete = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        ready_d = complete;
        error_d = complete && acc_err;
    end

    // A write takes priority over a simultaneous read; errored accesses touch nothing.
    assign mem_we = complete && !reset && acc_wr && !acc_err;
    assign mem_re = complete && !reset && acc_rd && !acc_wr && !acc_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
            op_rd_q <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            op_rd_q <= op_rd_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    // Registered read port doubles as the output register; zero outside read-ready cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (mem_re) begin
            rdata_q <= mem[acc_idx];
        end else begin
            rdata_q <= '0;
        end
    end

    assign dmem_read_data = rdata_q;
    assign dmem_ready     = ready_q;
    assign dmem_busy      = (state_q == S_BUSY);
    assign dmem_error     = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 1, 2, 5) driven in turn, checked
// every cycle against a transaction-level model plus literal expectations per transaction.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int NI    = 3;
    localparam int LATS [NI] = '{1, 2, 5};

    logic        clk;
    logic        reset;
    logic        rd_i    [NI];
    logic        wr_i    [NI];
    logic [63:0] addr_i  [NI];
    logic [63:0] wd_i    [NI];
    logic [63:0] rdata_o [NI];
    logic        ready_o [NI];
    logic        busy_o  [NI];
    logic        err_o   [NI];

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            dmem_responder #(
                .ADDR_WIDTH (64),
                .DATA_WIDTH (64),
                .DEPTH      (DEPTH),
                .LATENCY    (LATS[gi])
            ) u_dut (
                .clk             (clk),
                .reset           (reset),
                .dmem_addr       (addr_i[gi]),
                .dmem_write_data (wd_i[gi]),
                .dmem_read       (rd_i[gi]),
                .dmem_write      (wr_i[gi]),
                .dmem_read_data  (rdata_o[gi]),
                .dmem_ready      (ready_o[gi]),
                .dmem_busy       (busy_o[gi]),
                .dmem_error      (err_o[gi])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction-level model: one outstanding request per instance plus a word array.
    logic [63:0] mmem  [NI][DEPTH];
    logic        act   [NI];
    int          act_c [NI];
    logic        act_r [NI];
    logic        act_w [NI];
    logic [63:0] act_a [NI];
    logic [63:0] act_d [NI];
    logic        rst_prev = 1'b0;
    logic        chk_en   = 1'b0;
    logic        e_rdy, e_busy, e_err;
    logic [63:0] e_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int k, input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL inst=%0d %s got=%h want=%h (cycle %0d)", k, nm, got, exp, cyc);
        end
    endtask

    function automatic logic m_err(input logic [63:0] a);
`ifdef DMEM_ERR_EN
        return (a % 64'd8 != 64'd0) || (a >= 64'(DEPTH * 8));
`else
        return (a != a);
`endif
    endfunction

    function automatic int m_idx(input logic [63:0] a);
        return int'((a / 64'd8) % 64'(DEPTH));
    endfunction

    always @(negedge clk) begin
        if (rst_prev) chk_en = 1'b1;
        for (int k = 0; k < NI; k++) begin
            e_rdy  = 1'b0;
            e_busy = 1'b0;
            e_err  = 1'b0;
            e_data = 64'd0;
            if (rst_prev) begin
                act[k] = 1'b0;
            end else if (act[k]) begin
                if (cyc == act_c[k] + LATS[k]) begin
                    e_rdy = 1'b1;
                    e_err = m_err(act_a[k]);
                    if (!e_err && act_w[k])
                        mmem[k][m_idx(act_a[k])] = act_d[k];
                    else if (!e_err && act_r[k])
                        e_data = mmem[k][m_idx(act_a[k])];
                    act[k] = 1'b0;
                end else if (cyc > act_c[k]) begin
                    e_busy = 1'b1;
                end
            end
            if (chk_en) begin
                chk(k, "cyc_ready", 64'(ready_o[k]), 64'(e_rdy));
                chk(k, "cyc_busy",  64'(busy_o[k]),  64'(e_busy));
                chk(k, "cyc_error", 64'(err_o[k]),   64'(e_err));
                chk(k, "cyc_rdata", rdata_o[k],      e_data);
            end
        end
        rst_prev = reset;
    end

    task automatic issue(input int k, input logic r, input logic w,
                         input logic [63:0] a, input logic [63:0] d);
        rd_i[k]   = r;
        wr_i[k]   = w;
        addr_i[k] = a;
        wd_i[k]   = d;
        act_c[k]  = cyc;
        act_r[k]  = r;
        act_w[k]  = w;
        act_a[k]  = a;
        act_d[k]  = d;
        act[k]    = 1'b1;
    endtask

    // Called just after a rising edge; holds the request through the ready cycle, then drops it.
    task automatic xact(input int k, input logic r, input logic w, input logic [63:0] a,
                        input logic [63:0] d, output logic [63:0] got, output int lat,
                        output logic gerr);
        issue(k, r, w, a, d);
        lat  = -1;
        got  = 64'd0;
        gerr = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ready_o[k]) begin
                lat  = n;
                got  = rdata_o[k];
                gerr = err_o[k];
                break;
            end
        end
        @(posedge clk); #1;
        rd_i[k] = 1'b0;
        wr_i[k] = 1'b0;
        $display("xact inst=%0d rd=%0b wr=%0b addr=%h wdata=%h lat=%0d rdata=%h err=%0b",
                 k, r, w, a, d, lat, got, gerr);
    endtask

    task automatic abort_write(input int k, input logic [63:0] a, input logic [63:0] d);
        issue(k, 1'b0, 1'b1, a, d);
        if (LATS[k] > 1) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        wr_i[k] = 1'b0;
        repeat (LATS[k] + 2) @(posedge clk);
        #1;
        $display("xact inst=%0d aborted write addr=%h wdata=%h", k, a, d);
    endtask

    task automatic run_inst(input int k);
        logic [63:0] g;
        int          l;
        logic        e;
        logic [63:0] lexp;
        lexp = 64'(LATS[k]);

        xact(k, 1'b0, 1'b1, 64'h8, 64'hDEAD_BEEF_0123_4567, g, l, e);
        chk(k, "wr8_lat", 64'(l), lexp);
        chk(k, "wr8_data", g, 64'd0);
        xact(k, 1'b1, 1'b0, 64'h8, 64'd0, g, l, e);
        chk(k, "rd8_lat", 64'(l), lexp);
        chk(k, "rd8_data", g, 64'hDEAD_BEEF_0123_4567);

        xact(k, 1'b0, 1'b1, 64'h0,  64'h1111, g, l, e);
        xact(k, 1'b0, 1'b1, 64'h10, 64'h2222, g, l, e);
        xact(k, 1'b1, 1'b0, 64'h0,  64'd0, g, l, e);
        chk(k, "rd0_lat", 64'(l), lexp);
        chk(k, "rd0_data", g, 64'h1111);
        xact(k, 1'b1, 1'b0, 64'h10, 64'd0, g, l, e);
        chk(k, "rd10_lat", 64'(l), lexp);
        chk(k, "rd10_data", g, 64'h2222);

        xact(k, 1'b1, 1'b1, 64'h18, 64'h55, g, l, e);
        chk(k, "rw18_data", g, 64'd0);
        xact(k, 1'b1, 1'b0, 64'h18, 64'd0, g, l, e);
        chk(k, "rd18_data", g, 64'h55);

        xact(k, 1'b0, 1'b1, 64'h20, 64'hA5A5, g, l, e);
        abort_write(k, 64'h20, 64'hFFFF_FFFF);
        xact(k, 1'b1, 1'b0, 64'h20, 64'd0, g, l, e);
        chk(k, "rd20_after_abort", g, 64'hA5A5);

        xact(k, 1'b0, 1'b1, 64'h2003, 64'h7777, g, l, e);
        chk(k, "wr2003_lat", 64'(l), lexp);
`ifdef DMEM_ERR_EN
        chk(k, "wr2003_err", 64'(e), 64'd1);
        xact(k, 1'b1, 1'b0, 64'h0, 64'd0, g, l, e);
        chk(k, "rd0_unchanged", g, 64'h1111);
        xact(k, 1'b1, 1'b0, 64'h2003, 64'd0, g, l, e);
        chk(k, "rd2003_err", 64'(e), 64'd1);
        chk(k, "rd2003_data", g, 64'd0);
`else
        chk(k, "wr2003_err", 64'(e), 64'd0);
        xact(k, 1'b1, 1'b0, 64'h0, 64'd0, g, l, e);
        chk(k, "rd0_aliased", g, 64'h7777);
        xact(k, 1'b1, 1'b0, 64'h2003, 64'd0, g, l, e);
        chk(k, "rd2003_err", 64'(e), 64'd0);
        chk(k, "rd2003_data", g, 64'h7777);
`endif
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            rd_i[k]   = 1'b0;
            wr_i[k]   = 1'b0;
            addr_i[k] = 64'd0;
            wd_i[k]   = 64'd0;
            act[k]    = 1'b0;
            act_c[k]  = 0;
            act_r[k]  = 1'b0;
            act_w[k]  = 1'b0;
            act_a[k]  = 64'd0;
            act_d[k]  = 64'd0;
            for (int i = 0; i < DEPTH; i++) mmem[k][i] = 64'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk(k, "rst_ready", 64'(ready_o[k]), 64'd0);
            chk(k, "rst_busy",  64'(busy_o[k]),  64'd0);
            chk(k, "rst_rdata", rdata_o[k],      64'd0);
            chk(k, "rst_error", 64'(err_o[k]),   64'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) run_inst(k);
        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
